reg_dump: RTL and testbench
===========================

REG_DUMP -- requirements
Module: reg_dump

Interface
REQ-001 Parameter DATA_W, default 8, width of register data and of the stream output.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 start  input  1  request a dump; sampled only in IDLE.
REQ-005 first_addr  input  2  index of the first register to read; sampled with start.
REQ-006 count  input  3  number of registers to read; sampled with start.
REQ-007 abort  input  1  cancels an in-progress dump.
REQ-008 rd_addr  output  2  read address to the register file read port.
REQ-009 rd_data  input  DATA_W  register contents for rd_addr, combinational, valid in the same cycle.
REQ-010 out_data  output  DATA_W  streamed register value.
REQ-011 out_valid  output  1  out_data holds a word.
REQ-012 out_ready  input  1  consumer accepts; a transfer occurs when out_valid && out_ready.
REQ-013 out_last  output  1  marks the final word of the dump.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 done  output  1  one-cycle pulse after the final word transfers.

Function
REQ-016 The FSM SHALL have four states: IDLE, FETCH, SEND, DONE.
REQ-017 IDLE, start=1: ptr<=first_addr; remaining<=count; go to FETCH.
REQ-018 IDLE, start=1 with count=0 or count>4: remaining SHALL be loaded as 4.
REQ-019 start SHALL be ignored in every state other than IDLE.
REQ-020 rd_addr SHALL equal the registered ptr at all times, including in IDLE.
REQ-021 FETCH SHALL last exactly one cycle: out_data<=rd_data; out_last<=(remaining==1); go to SEND.
REQ-022 out_valid SHALL be 1 exactly in SEND, so the first word is valid 2 cycles after the start cycle.
REQ-023 SEND with out_ready=0: stay in SEND; out_data and out_last SHALL hold stable.
REQ-024 SEND with out_ready=1 and remaining>1: ptr<=ptr+1 mod 4; remaining<=remaining-1; go to FETCH.
REQ-025 SEND with out_ready=1 and remaining==1: go to DONE.
REQ-026 Address increment SHALL wrap 3->0 (first_addr=3, count=2 reads r3 then r0).
REQ-027 DONE SHALL assert done for one cycle, then go to IDLE.
REQ-028 A start seen in the DONE cycle SHALL be ignored.
REQ-029 Maximum throughput SHALL be one word per 2 cycles; a dump of N words with out_ready held at 1 SHALL take 2N+1 cycles from start to the done pulse.
REQ-030 abort=1 in FETCH, SEND or DONE: go to IDLE next cycle; out_valid=0 from that cycle; done SHALL NOT pulse.
REQ-031 abort in the same cycle as a SEND transfer SHALL take priority: the next state SHALL be IDLE, and done SHALL NOT pulse even when the transfer carried the last word.
REQ-032 abort in IDLE SHALL have no effect.
REQ-033 The block SHALL never drive write signals to the register file; it is read-only.

Reset
REQ-034 When rst=1 at a clock edge, the following SHALL hold on the next cycle regardless of state: state=IDLE, ptr=0, remaining=0, out_data=0, out_valid=0, out_last=0, busy=0, done=0.
REQ-035 rst SHALL take priority over start and abort.
REQ-036 A reset during a dump SHALL discard it with no done pulse.

Verification
REQ-037 Registers r0..r3 = 0x11, 0x22, 0x33, 0x44; first_addr=0, count=4, out_ready=1 -> words 11, 22, 33, 44 on cycles 2, 4, 6, 8; out_last only with 44; done on cycle 9.
REQ-038 first_addr=3, count=2 -> words 44 then 11 (wrap-around); out_last with 11.
REQ-039 count=0 and count=7 -> 4 words each.
REQ-040 out_ready low for 3 cycles while the first word is valid -> out_data=22 stable and valid held; the stream then continues normally.
REQ-041 abort asserted in the cycle the last word transfers -> IDLE next cycle; done stays 0; busy=0.
REQ-042 rst asserted mid-SEND -> all outputs 0 on the next cycle; a following start (first_addr=1, count=1) yields the single word 22 with out_last=1.

Source files
------------

// File: rtl/reg_dump.sv
// Register-file dump engine.
// Reads up to four registers from a 4-entry register file read port, starting
// at a given index and wrapping 3->0. Each word is streamed out on a
// valid/ready interface. Every word costs one FETCH cycle, which captures
// rd_data, and at least one SEND cycle, which presents the word. Once the
// final word has been accepted, a single-cycle done pulse is raised.
// The block only ever reads the register file; it has no write path.
module reg_dump #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        first_addr,
    input  logic [2:0]        count,
    input  logic              abort,
    output logic [1:0]        rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state,     state_nxt;
    logic [1:0]          ptr,       ptr_nxt;
    logic [2:0]          remaining, remaining_nxt;
    logic [DATA_W-1:0]   data_q,    data_nxt;
    logic                last_q,    last_nxt;

    // The requested length is clamped: a count of 0, or any count above 4,
    // means "dump all four registers".
    logic [2:0] count_eff;
    assign count_eff = (count == 3'd0 || count > 3'd4) ? 3'd4 : count;

    // State register plus datapath registers. A synchronous reset clears
    // everything back to an idle, all-zero state.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so that every
        // register samples the values from before the edge, regardless of the
        // order in which the statements are written.
        if (rst) begin
            state     <= IDLE;
            ptr       <= 2'd0;
            remaining <= 3'd0;
            data_q    <= '0;
            last_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            remaining <= remaining_nxt;
            data_q    <= data_nxt;
            last_q    <= last_nxt;
        end
    end

    // Next-state and next-datapath logic. abort wins over everything except
    // reset; start is looked at only while the engine is idle.
    always_comb begin
        // NOTE: each variable gets its hold value first, so a path that does
        // not assign it cannot infer a latch.
        state_nxt     = state;
        ptr_nxt       = ptr;
        remaining_nxt = remaining;
        data_nxt      = data_q;
        last_nxt      = last_q;

        case (state)
            IDLE: begin
                if (start) begin
                    ptr_nxt       = first_addr;
                    remaining_nxt = count_eff;
                    state_nxt     = FETCH;
                end
            end

            FETCH: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else begin
                    data_nxt  = rd_data;
                    last_nxt  = (remaining == 3'd1);
                    state_nxt = SEND;
                end
            end

            SEND: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (out_ready) begin
                    if (remaining > 3'd1) begin
                        ptr_nxt       = ptr + 2'd1;   // 2-bit add wraps 3 -> 0
                        remaining_nxt = remaining - 3'd1;
                        state_nxt     = FETCH;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end

            DONE: begin
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the registered state. The read address always
    // follows the pointer, even while idle. An abort arriving in the DONE
    // cycle suppresses the done pulse.
    assign rd_addr   = ptr;
    assign out_data  = data_q;
    assign out_last  = last_q;
    assign out_valid = (state == SEND);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE) && !abort;

endmodule

// File: tb/tb_reg_dump.sv
// Directed testbench for reg_dump. The bench models the register file as
// r0..r3 = 11, 22, 33, 44. Every expected value is written out by hand.
module tb_reg_dump;

    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [1:0]        first_addr;
    logic [2:0]        count;
    logic              abort;
    logic [1:0]        rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              busy;
    logic              done;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] regs [4];
    initial begin
        regs[0] = 8'h11;
        regs[1] = 8'h22;
        regs[2] = 8'h33;
        regs[3] = 8'h44;
    end

    // The register file read port is combinational.
    assign rd_data = regs[rd_addr];

    always #5 clk = ~clk;

    reg_dump #(.DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .first_addr (first_addr),
        .count      (count),
        .abort      (abort),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done)
    );

    // Advance one clock, then settle just past the edge. All stimulus is
    // changed, and all outputs are sampled, at this point.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Run one complete dump with out_ready held high. The expected words are
    // packed first word in the top byte. n is the word count the dump must
    // produce. The done pulse must fall exactly 2n+1 cycles after start.
    task automatic dump(input string name, input logic [1:0] fa, input logic [2:0] cnt,
                        input int n, input logic [31:0] words);
        logic [7:0] w;
        first_addr = fa;
        count      = cnt;
        start      = 1'b1;
        step();                                  // cycle 1: FETCH
        start      = 1'b0;
        chk({name, " c1 busy"},  busy, 1);
        chk({name, " c1 valid"}, out_valid, 0);
        for (int i = 0; i < n; i++) begin
            w = words[31 - 8*i -: 8];
            step();                              // cycle 2i+2: SEND
            chk($sformatf("%s w%0d valid", name, i), out_valid, 1);
            chk($sformatf("%s w%0d data", name, i), out_data, w);
            chk($sformatf("%s w%0d last", name, i), out_last, (i == n - 1) ? 1 : 0);
            chk($sformatf("%s w%0d done", name, i), done, 0);
            step();                              // cycle 2i+3
            if (i < n - 1) begin
                chk($sformatf("%s fetch%0d valid", name, i + 1), out_valid, 0);
                chk($sformatf("%s fetch%0d done", name, i + 1), done, 0);
            end else begin
                chk({name, " done pulse"}, done, 1);
                chk({name, " done busy"}, busy, 1);
                chk({name, " done valid"}, out_valid, 0);
            end
        end
        step();                                  // back in IDLE
        chk({name, " idle busy"}, busy, 0);
        chk({name, " idle done"}, done, 0);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b1;    // reset must win over start
        first_addr = 2'd2;
        count      = 3'd3;
        abort      = 1'b0;
        out_ready  = 1'b1;
        step();
        step();
        start = 1'b0;
        chk("reset busy",     busy, 0);
        chk("reset valid",    out_valid, 0);
        chk("reset data",     out_data, 0);
        chk("reset last",     out_last, 0);
        chk("reset done",     done, 0);
        chk("reset rd_addr",  rd_addr, 0);
        rst = 1'b0;
        step();
        chk("post reset idle", busy, 0);

        // Basic dump of all four registers: 11 22 33 44, done on cycle 9.
        dump("full", 2'd0, 3'd4, 4, 32'h11223344);
        // Address wraps from 3 back to 0.
        dump("wrap", 2'd3, 3'd2, 2, 32'h44110000);
        // A count of 0 and a count of 7 are both clamped to 4 words.
        dump("cnt0", 2'd2, 3'd0, 4, 32'h33441122);
        dump("cnt7", 2'd1, 3'd7, 4, 32'h22334411);

        // Hold back-pressure for 3 cycles on the first word, with a spurious
        // start pending throughout. Then start again during the DONE cycle.
        first_addr = 2'd1;
        count      = 3'd2;
        start      = 1'b1;
        step();                                  // FETCH
        first_addr = 2'd3;                       // start stays high: must be ignored
        step();                                  // SEND, word 22
        chk("stall w0 data", out_data, 8'h22);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("stall%0d valid", i), out_valid, 1);
            chk($sformatf("stall%0d data", i),  out_data, 8'h22);
            chk($sformatf("stall%0d last", i),  out_last, 0);
        end
        out_ready = 1'b1;
        step();                                  // FETCH
        chk("stall fetch valid", out_valid, 0);
        step();                                  // SEND, word 33
        chk("stall w1 data",  out_data, 8'h33);
        chk("stall w1 last",  out_last, 1);
        chk("stall rd_addr",  rd_addr, 2);
        step();                                  // DONE, start still high
        chk("stall done", done, 1);
        step();                                  // IDLE; the start seen in DONE was dropped
        chk("start in done ignored", busy, 0);
        start = 1'b0;
        step();
        chk("still idle", busy, 0);

        // Abort arriving in the same cycle as the transfer of the last word.
        first_addr = 2'd0;
        count      = 3'd1;
        start      = 1'b1;
        step();
        start = 1'b0;
        step();                                  // SEND, word 11, last
        chk("abort w data", out_data, 8'h11);
        chk("abort w last", out_last, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort busy",  busy, 0);
        chk("abort done",  done, 0);
        chk("abort valid", out_valid, 0);
        step();
        chk("abort no late done", done, 0);

        // Abort while idle has no effect.
        abort = 1'b1;
        step();
        chk("idle abort busy", busy, 0);
        chk("idle abort done", done, 0);
        abort = 1'b0;

        // Reset in the middle of a SEND, then a clean single-word dump.
        first_addr = 2'd2;
        count      = 3'd3;
        start      = 1'b1;
        step();
        start = 1'b0;
        step();                                  // SEND, word 33
        chk("pre-rst data", out_data, 8'h33);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid rst busy",    busy, 0);
        chk("mid rst valid",   out_valid, 0);
        chk("mid rst data",    out_data, 0);
        chk("mid rst last",    out_last, 0);
        chk("mid rst done",    done, 0);
        chk("mid rst rd_addr", rd_addr, 0);
        step();
        chk("mid rst no done", done, 0);
        dump("after rst", 2'd1, 3'd1, 1, 32'h22000000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
